fpnew_req_arbiter: RTL and testbench
====================================

# fpnew_req_arbiter

Shares one FPU instance between `NumReq` independent requesters, for example the scalar core and a vector lane. Per-cycle behaviour:
- Arbitrates issue round-robin and holds the grant until the FPU accepts.
- Appends the requester index to the downstream tag.
- Caps in-flight operations per requester with credit counters.
- Routes each completed result back to its owner using the returned index.

It sits directly between the requesters and the FPU top-level input/output handshakes.

## Interface
Parameters:
- `NumReq`, 2: number of requesters, ≥ 2.
- `MaxOutstanding`, 4: maximum in-flight operations per requester, ≥ 1.
- `ReqType`, logic: opaque request payload (operands, op, formats, mask).
- `RspType`, logic: opaque response payload (result, status, ext bit).
- `TagType`, logic: requester-side tag.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: flush, forwarded to the FPU by the parent.
- `req_valid_i` in `[NumReq]`: request valid.
- `req_ready_o` out `[NumReq]`: request accepted.
- `req_data_i` in `ReqType[NumReq]`: request payload.
- `req_tag_i` in `TagType[NumReq]`: request tag.
- `fpu_valid_o` out 1, `fpu_ready_i` in 1: FPU input handshake.
- `fpu_data_o` out `ReqType`: payload of the granted requester.
- `fpu_tag_o` out `fpu_tag_t`: `{id, tag}`.
- `fpu_out_valid_i` in 1, `fpu_out_ready_o` out 1: FPU output handshake.
- `fpu_rsp_i` in `RspType`, `fpu_tag_i` in `fpu_tag_t`: FPU result and returned tag.
- `rsp_valid_o` out `[NumReq]`, `rsp_ready_i` in `[NumReq]`: response handshake per requester.
- `rsp_data_o` out `RspType`, `rsp_tag_o` out `TagType`: response payload and tag, broadcast to all requesters.
- `busy_o` out 1: operations in flight or an issue pending.

## Operation
State:
- `prio_q`: round-robin pointer, `IdxW = $clog2(NumReq)` bits.
- `lock_q`, `lock_idx_q`: grant lock and the locked index.
- `cnt_q[k]`: credit counter per requester, `$clog2(MaxOutstanding+1)` bits.

Issue arbitration:
- Requester k is eligible when `req_valid_i[k] && cnt_q[k] < MaxOutstanding`.
- When not locked, the winner is the first eligible index at or after `prio_q`, wrapping modulo `NumReq`.
- `fpu_valid_o = any eligible || lock_q`.
- `fpu_data_o` and `fpu_tag_o.tag` come from the winner; `fpu_tag_o.id` = winner index.
- `req_ready_o[k] = fpu_ready_i && winner == k`. Only the winner's bit is ever set.

Grant lock:
- When `fpu_valid_o && !fpu_ready_i`, set `lock_q`, `lock_idx_q = winner`.
- While locked the winner is `lock_idx_q`, regardless of other requesters and of its own credit.
- The locked requester must keep `req_valid_i` and its data stable; an assertion checks this.

On issue accept (`fpu_valid_o && fpu_ready_i`):
- `prio_q <= winner + 1`, wrapping at `NumReq`.
- Clear `lock_q`.
- `cnt_q[winner]++`.

Response routing:
- `rsp_valid_o[fpu_tag_i.id] = fpu_out_valid_i`; all other bits are 0.
- `fpu_out_ready_o = rsp_ready_i[fpu_tag_i.id]`.
- `rsp_data_o = fpu_rsp_i`, `rsp_tag_o = fpu_tag_i.tag`.
- On response handshake, `cnt_q[id]--`.

Credit counter rules:
- Accept and response handshake for the same k in the same cycle leave `cnt_q[k]` unchanged.
- A response with `cnt_q[id] == 0` or `id >= NumReq` is an assertion error.
- `cnt_q[k] > MaxOutstanding` is an assertion error.

Flush (`flush_i` = 1):
- Combinational effects in that cycle: `fpu_valid_o = 0`, `req_ready_o = 0`, `rsp_valid_o = 0`, `fpu_out_ready_o = 1` (in-flight FPU results are drained and dropped).
- Register effects: `cnt_q <= 0`, `lock_q <= 0`. `prio_q` is held.

`busy_o = |cnt_q || fpu_valid_o`.

## Timing
- Issue and response paths are combinational: zero cycles of latency through the block, no buffering.
- All state updates on the rising clock edge.
- Reset values: `prio_q = 0`, `lock_q = 0`, `cnt_q = 0`.
- Outputs with reset asserted and no inputs active: `fpu_valid_o`, `req_ready_o`, `rsp_valid_o`, `busy_o` all 0.
- Reset asserted mid-operation aborts everything. The parent resets the FPU in the same cycle.
- A requester at `MaxOutstanding` regains eligibility in the cycle after its response handshake.
- No combinational path exists from `fpu_ready_i` to `fpu_valid_o`.
- A combinational path exists from `rsp_ready_i` to `fpu_out_ready_o`.

## Structure
- Put `fpu_tag_t` (`{logic [IdxW-1:0] id; TagType tag;}`) as a module-local typedef, because it depends on parameters.
- No new fpnew_pkg entries.
- Add one sub-module, `fpnew_credit_counter`, parameterised by `MaxOutstanding`, with inputs `inc`, `dec`, `clr` and outputs `cnt`, `full`.
- Instantiate one `fpnew_credit_counter` per requester.
- Arbitration, lock and response demux live in the top module.

## Test plan
- **Alternating issue**: both requesters hold valid, `fpu_ready_i = 1` → grants alternate 0, 1, 0, 1; `fpu_tag_o.id` matches each cycle.
- **Grant lock**: hold `fpu_ready_i = 0` for 3 cycles with requester 1 granted while requester 0 also asserts valid → grant stays on 1 and the payload is stable; after accept, the next grant goes to 0.
- **Credit limit**: `MaxOutstanding = 4`, requester 0 only, no responses → exactly 4 accepts, then `req_ready_o[0] = 0` while valid is held; one response handshake → a 5th accept occurs the following cycle.
- **Response routing**: return a response with id = 1 while `rsp_ready_i = 2'b01` → `rsp_valid_o = 2'b10`, `fpu_out_ready_o = 0`; raise `rsp_ready_i[1]` → handshake completes and `cnt_q[1]` decrements.
- **Simultaneous accept and response**: issue accept and response for requester 0 in the same cycle with `cnt_q[0] = 2` → `cnt_q[0]` stays 2.
- **Flush and reset**: pulse `flush_i` with 3 operations in flight and a lock held → counters = 0, lock cleared, a concurrent FPU response is consumed without `rsp_valid_o`. Assert `rst_ni` mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/fpnew_req_arbiter_pkg.sv
// Shared defaults and the round-robin index helper for the FPU request arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fpnew_req_arbiter_pkg;

  localparam int unsigned DefaultNumReq         = 2;
  localparam int unsigned DefaultMaxOutstanding = 4;

  // (base + off) modulo n, for base < n and off <= n; avoids a real divider.
  function automatic int unsigned rr_idx(int unsigned base, int unsigned off, int unsigned n);
    int unsigned sum;
    sum = base + off;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/fpnew_credit_counter.sv
// Per-requester in-flight operation counter with a full flag at MaxOutstanding.
// Latency: count updates on the clock edge after inc/dec/clr; full is combinational from the count.
// Backpressure: none internally; the owner stops issuing while full is high.
module fpnew_credit_counter
  import fpnew_req_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            dec_i,
  input  logic            clr_i,
  output logic [CntW-1:0] cnt_o,
  output logic            full_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, simultaneous inc and dec cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == CntW'(MaxOutstanding));

  // A completion can only return for an operation that was issued.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dec_i && !clr_i) |-> (cnt_q != '0));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntW'(MaxOutstanding));

endmodule

// File: rtl/fpnew_req_arbiter.sv
// Shares one FPU between NumReq requesters: round-robin issue with grant lock, per-requester credits, result demux.
// Latency: zero cycles on both issue and response paths (purely combinational, no buffering).
// Backpressure: grant held until fpu_ready_i; requesters at MaxOutstanding are skipped; results wait on the owner's rsp_ready_i.
module fpnew_req_arbiter
  import fpnew_req_arbiter_pkg::*;
#(
  parameter int unsigned NumReq         = DefaultNumReq,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding,
  parameter type         ReqType        = logic,
  parameter type         RspType        = logic,
  parameter type         TagType        = logic,
  localparam int unsigned IdxW    = $clog2(NumReq),
  localparam int unsigned TagW    = $bits(TagType),
  localparam int unsigned FpuTagW = IdxW + TagW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [NumReq-1:0]  req_valid_i,
  output logic [NumReq-1:0]  req_ready_o,
  input  ReqType             req_data_i [NumReq],
  input  TagType             req_tag_i  [NumReq],
  output logic               fpu_valid_o,
  input  logic               fpu_ready_i,
  output ReqType             fpu_data_o,
  output logic [FpuTagW-1:0] fpu_tag_o,
  input  logic               fpu_out_valid_i,
  output logic               fpu_out_ready_o,
  input  RspType             fpu_rsp_i,
  input  logic [FpuTagW-1:0] fpu_tag_i,
  output logic [NumReq-1:0]  rsp_valid_o,
  input  logic [NumReq-1:0]  rsp_ready_i,
  output RspType             rsp_data_o,
  output TagType             rsp_tag_o,
  output logic               busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic [IdxW-1:0] id;
    TagType          tag;
  } fpu_tag_t;

  logic [IdxW-1:0]             prio_q, prio_d;
  logic                        lock_q, lock_d;
  logic [IdxW-1:0]             lock_idx_q, lock_idx_d;
  logic [IdxW-1:0]             rr_cand [NumReq];
  logic [IdxW-1:0]             arb_idx, win_idx, rsp_id;
  logic [NumReq-1:0]           elig, full, inc, dec;
  logic [NumReq-1:0][CntW-1:0] cnt;
  logic                        kill, issue_hs, route_rdy;
  fpu_tag_t                    tag_out, tag_in;

  // Reset and flush both silence every handshake this cycle.
  assign kill = flush_i || !rst_ni;
  assign elig = req_valid_i & ~full;

  // Candidate order for this cycle: prio_q, prio_q+1, ... wrapping.
  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      rr_cand[i] = IdxW'(rr_idx(32'(prio_q), i, NumReq));
    end
  end

  // Pick the first eligible candidate; scanning backwards lets the earliest one win.
  always_comb begin
    arb_idx = prio_q;
    for (int off = int'(NumReq) - 1; off >= 0; off--) begin
      if (elig[rr_cand[off]]) arb_idx = rr_cand[off];
    end
  end

  // A stalled grant stays put regardless of what the other requesters do.
  assign win_idx     = lock_q ? lock_idx_q : arb_idx;
  assign fpu_valid_o = !kill && (lock_q || (|elig));
  assign issue_hs    = fpu_valid_o && fpu_ready_i;

  // Issue-side mux: winner's payload, tag extended with its index, ready and credit increment.
  always_comb begin
    req_ready_o = '0;
    inc         = '0;
    if (issue_hs) begin
      req_ready_o[win_idx] = 1'b1;
      inc[win_idx]         = 1'b1;
    end
    fpu_data_o  = req_data_i[win_idx];
    tag_out.id  = win_idx;
    tag_out.tag = req_tag_i[win_idx];
  end

  assign fpu_tag_o = tag_out;

  // Grant lock and round-robin pointer next state; the pointer survives a flush.
  always_comb begin
    prio_d     = prio_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      lock_d = 1'b0;
    end else if (issue_hs) begin
      lock_d = 1'b0;
      prio_d = IdxW'(rr_idx(32'(win_idx), 1, NumReq));
    end else if (fpu_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = win_idx;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Response demux: the returned index picks the owner's valid and ready.
  assign tag_in = fpu_tag_i;
  assign rsp_id = tag_in.id;

  always_comb begin
    rsp_valid_o = '0;
    route_rdy   = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (rsp_id == IdxW'(k)) begin
        route_rdy      = rsp_ready_i[k];
        rsp_valid_o[k] = !kill && fpu_out_valid_i;
      end
    end
    dec = rsp_valid_o & rsp_ready_i;
  end

  // During a flush in-flight results are drained and dropped.
  assign fpu_out_ready_o = flush_i || (rst_ni && route_rdy);
  assign rsp_data_o      = fpu_rsp_i;
  assign rsp_tag_o       = tag_in.tag;

  for (genvar k = 0; k < NumReq; k++) begin : g_credit
    fpnew_credit_counter #(
      .MaxOutstanding (MaxOutstanding)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (inc[k]),
      .dec_i  (dec[k]),
      .clr_i  (flush_i),
      .cnt_o  (cnt[k]),
      .full_o (full[k])
    );
  end

  assign busy_o = (|cnt) || fpu_valid_o;

  // The locked requester must keep its request up and unchanged until accepted.
  a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    lock_q |-> (req_valid_i[lock_idx_q] && (req_data_i[lock_idx_q] == $past(fpu_data_o))));

  a_rsp_id_range: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    fpu_out_valid_i |-> (32'(rsp_id) < NumReq));

endmodule

// File: tb/tb_fpnew_req_arbiter.sv
// Self-checking bench for fpnew_req_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Latency: outputs sampled 1ns after the negedge that drives inputs; state checked 1ns after posedge.
// Backpressure: randomized fpu_ready / rsp_ready, credit exhaustion and flushes.
module tb_fpnew_req_arbiter;

  localparam int N   = 2;
  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [15:0] req_data [2];
  logic [3:0]  req_tag  [2];
  logic        fpu_valid, fpu_ready, fpu_out_valid, fpu_out_ready;
  logic [15:0] fpu_data, fpu_rsp, rsp_data;
  logic [4:0]  fpu_tag, fpu_tag_in;
  logic [3:0]  rsp_tag;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding count per requester, rotation pointer, held grant.
  int m_cnt [2];
  int m_prio;
  bit m_lock;
  int m_lidx;

  always #5 clk = ~clk;

  fpnew_req_arbiter #(
    .NumReq         (N),
    .MaxOutstanding (MAX),
    .ReqType        (logic [15:0]),
    .RspType        (logic [15:0]),
    .TagType        (logic [3:0])
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_data_i      (req_data),
    .req_tag_i       (req_tag),
    .fpu_valid_o     (fpu_valid),
    .fpu_ready_i     (fpu_ready),
    .fpu_data_o      (fpu_data),
    .fpu_tag_o       (fpu_tag),
    .fpu_out_valid_i (fpu_out_valid),
    .fpu_out_ready_o (fpu_out_ready),
    .fpu_rsp_i       (fpu_rsp),
    .fpu_tag_i       (fpu_tag_in),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_data_o      (rsp_data),
    .rsp_tag_o       (rsp_tag),
    .busy_o          (busy)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid     = 2'b00;
    fpu_ready     = 1'b0;
    fpu_out_valid = 1'b0;
    fpu_tag_in    = 5'h0;
    fpu_rsp       = 16'h0;
    rsp_ready     = 2'b00;
    flush         = 1'b0;
  endtask

  task automatic model_reset();
    m_cnt  = '{0, 0};
    m_prio = 0;
    m_lock = 1'b0;
    m_lidx = 0;
  endtask

  // One clock: compare combinational outputs with the model, advance the model, compare credits.
  task automatic tick();
    int         win;
    int         id;
    logic       exp_fv, exp_or;
    logic [1:0] exp_rr, exp_rv;
    #1;
    win = -1;
    if (!flush) begin
      if (m_lock) win = m_lidx;
      else begin
        for (int i = 0; i < N; i++) begin
          if (win < 0 && req_valid[(m_prio + i) % N] && m_cnt[(m_prio + i) % N] < MAX)
            win = (m_prio + i) % N;
        end
      end
    end
    exp_fv = (win >= 0);
    check("fpu_valid", 32'(fpu_valid), 32'(exp_fv));
    if (exp_fv) begin
      check("fpu_id", 32'(fpu_tag[4]), 32'(win));
      check("fpu_tag", 32'(fpu_tag[3:0]), 32'(req_tag[win]));
      check("fpu_data", 32'(fpu_data), 32'(req_data[win]));
    end
    exp_rr = (exp_fv && fpu_ready) ? 2'(2'b01 << win) : 2'b00;
    check("req_ready", 32'(req_ready), 32'(exp_rr));
    id     = int'(fpu_tag_in[4]);
    exp_rv = (!flush && fpu_out_valid) ? 2'(2'b01 << id) : 2'b00;
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    exp_or = flush ? 1'b1 : rsp_ready[id];
    check("out_ready", 32'(fpu_out_ready), 32'(exp_or));
    if (exp_rv != 2'b00) begin
      check("rsp_data", 32'(rsp_data), 32'(fpu_rsp));
      check("rsp_tag", 32'(rsp_tag), 32'(fpu_tag_in[3:0]));
    end
    check("busy", 32'(busy), 32'((m_cnt[0] + m_cnt[1] > 0) || exp_fv));
    if (flush) begin
      m_cnt  = '{0, 0};
      m_lock = 1'b0;
    end else begin
      if (exp_fv && !fpu_ready) begin
        m_lock = 1'b1;
        m_lidx = win;
      end
      if (exp_fv && fpu_ready) begin
        m_lock = 1'b0;
        m_prio = (win + 1) % N;
        m_cnt[win]++;
      end
      if (exp_rv != 2'b00 && rsp_ready[id]) m_cnt[id]--;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) check($sformatf("cnt%0d", k), 32'(dut.cnt[k]), 32'(m_cnt[k]));
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int other;
    int id;
    rst_n       = 1'b0;
    req_data[0] = 16'hA000;
    req_data[1] = 16'hB111;
    req_tag[0]  = 4'h3;
    req_tag[1]  = 4'h9;
    idle_inputs();
    model_reset();
    #1;
    check("rst_fpu_valid", 32'(fpu_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Alternating issue with both requesters valid.
    req_valid = 2'b11;
    fpu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alt_grant", 32'(fpu_tag[4]), 32'(i % 2));
      tick();
    end
    idle_inputs();
    do_flush();

    // Grant lock on requester 1 while requester 0 also asks.
    req_valid = 2'b01;
    fpu_ready = 1'b1;
    tick();
    req_valid = 2'b11;
    fpu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lock_grant", 32'(fpu_tag[4]), 32'd1);
      check("lock_data", 32'(fpu_data), 32'hB111);
      tick();
    end
    fpu_ready = 1'b1;
    tick();
    #1;
    check("post_lock_grant", 32'(fpu_tag[4]), 32'd0);
    tick();
    idle_inputs();
    do_flush();

    // Credit limit on requester 0.
    req_valid = 2'b01;
    fpu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("credit_accept", 32'(req_ready), 32'b01);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      check("credit_block", 32'(req_ready), 32'b00);
      tick();
    end
    fpu_out_valid = 1'b1;
    fpu_tag_in    = {1'b0, 4'h3};
    fpu_rsp       = 16'h1234;
    rsp_ready     = 2'b01;
    #1;
    check("credit_still_full", 32'(req_ready), 32'b00);
    tick();
    fpu_out_valid = 1'b0;
    rsp_ready     = 2'b00;
    #1;
    check("credit_fifth", 32'(req_ready), 32'b01);
    tick();
    idle_inputs();
    do_flush();

    // Response routing to requester 1.
    req_valid = 2'b10;
    fpu_ready = 1'b1;
    tick();
    tick();
    idle_inputs();
    fpu_out_valid = 1'b1;
    fpu_tag_in    = {1'b1, 4'h9};
    fpu_rsp       = 16'h5A5A;
    rsp_ready     = 2'b01;
    #1;
    check("route_valid", 32'(rsp_valid), 32'b10);
    check("route_ready", 32'(fpu_out_ready), 32'd0);
    tick();
    rsp_ready = 2'b11;
    tick();
    check("route_dec", 32'(dut.cnt[1]), 32'd1);
    idle_inputs();
    do_flush();

    // Accept and response for requester 0 in the same cycle.
    req_valid = 2'b01;
    fpu_ready = 1'b1;
    tick();
    tick();
    fpu_out_valid = 1'b1;
    fpu_tag_in    = {1'b0, 4'h3};
    rsp_ready     = 2'b01;
    tick();
    check("simul_cnt", 32'(dut.cnt[0]), 32'd2);
    idle_inputs();
    do_flush();

    // Flush with operations in flight, a held lock and a concurrent result.
    req_valid = 2'b11;
    fpu_ready = 1'b1;
    repeat (3) tick();
    fpu_ready = 1'b0;
    tick();
    other         = 1 - m_lidx;
    id            = (m_cnt[0] > 0) ? 0 : 1;
    flush         = 1'b1;
    fpu_out_valid = 1'b1;
    fpu_tag_in    = {id[0], 4'h7};
    #1;
    check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    check("flush_out_ready", 32'(fpu_out_ready), 32'd1);
    check("flush_fpu_valid", 32'(fpu_valid), 32'd0);
    check("flush_req_ready", 32'(req_ready), 32'd0);
    tick();
    idle_inputs();
    check("flush_cnt0", 32'(dut.cnt[0]), 32'd0);
    check("flush_cnt1", 32'(dut.cnt[1]), 32'd0);
    req_valid = 2'(2'b01 << other);
    #1;
    check("flush_unlock", 32'(fpu_tag[4]), 32'(other));
    tick();

    // Reset mid-stream with inputs still active.
    req_valid     = 2'b11;
    fpu_ready     = 1'b1;
    fpu_out_valid = 1'b1;
    rsp_ready     = 2'b11;
    rst_n         = 1'b0;
    #1;
    check("mid_rst_fpu_valid", 32'(fpu_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    idle_inputs();
    model_reset();
    rst_n = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      if (m_lock) req_valid[m_lidx] = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (!(m_lock && m_lidx == k)) begin
          req_data[k] = 16'($urandom);
          req_tag[k]  = 4'($urandom);
        end
      end
      fpu_ready     = ($urandom_range(0, 3) != 0);
      rsp_ready     = 2'($urandom_range(0, 3));
      flush         = ($urandom_range(0, 39) == 0);
      fpu_out_valid = 1'b0;
      if ((m_cnt[0] > 0 || m_cnt[1] > 0) && $urandom_range(0, 1) == 1) begin
        id = int'($urandom_range(0, 1));
        if (m_cnt[id] == 0) id = 1 - id;
        fpu_out_valid = 1'b1;
        fpu_tag_in    = {id[0], 4'($urandom)};
        fpu_rsp       = 16'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
